// File: rtl/adder_scoreboard.sv
// In-order result checker: queues expected words, compares each DUT result
// against the oldest one, and keeps counters plus a capture of the first failure.
module adder_scoreboard #(
    parameter int WIDTH       = 17,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     ref_valid,
    input  logic [WIDTH-1:0]         ref_data,
    input  logic                     res_valid,
    input  logic [WIDTH-1:0]         res_data,
    output logic                     error,
    output logic                     err_sticky,
    output logic                     halted,
    output logic                     overflow,
    output logic                     underflow,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         txn_cnt,
    output logic [CNT_W-1:0]         match_cnt,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [CNT_W-1:0]         first_err_idx,
    output logic [WIDTH-1:0]         first_err_res,
    output logic [WIDTH-1:0]         first_err_ref
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      count_q, count_d;
    logic               error_q, error_d;
    logic               sticky_q, sticky_d;
    logic               halted_q, halted_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [CNT_W-1:0]   txn_q, txn_d;
    logic [CNT_W-1:0]   match_q, match_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   fidx_q, fidx_d;
    logic [WIDTH-1:0]   fres_q, fres_d;
    logic [WIDTH-1:0]   fref_q, fref_d;

    logic               active, empty, full;
    logic               do_cmp, under, pop, push, ovf_evt, mismatch;
    logic [WIDTH-1:0]   cmp_ref;

    // An empty FIFO with a same-cycle push compares against the incoming word
    // directly; with no push there is nothing to compare against, so the
    // reference is all-X and the result is forced to fail.
    always_comb begin
        active  = (state_q == RUN) && !clear;
        empty   = (count_q == '0);
        full    = (count_q == FULL_LVL);
        do_cmp  = active && res_valid;
        under   = do_cmp && empty && !ref_valid;
        pop     = do_cmp && !empty;
        push    = active && ref_valid && !(do_cmp && empty) && (!full || pop);
        ovf_evt = active && ref_valid && full && !res_valid;
        if (!empty) begin
            cmp_ref = mem_q[rd_ptr_q];
        end else if (ref_valid) begin
            cmp_ref = ref_data;
        end else begin
            cmp_ref = {WIDTH{1'bx}};
        end
        mismatch = do_cmp && (under || (res_data !== cmp_ref));
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        error_d  = 1'b0;
        sticky_d = sticky_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        txn_d    = txn_q;
        match_d  = match_q;
        err_d    = err_q;
        fidx_d   = fidx_q;
        fres_d   = fres_q;
        fref_d   = fref_q;
        if (clear) begin
            state_d  = RUN;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            sticky_d = 1'b0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            txn_d    = '0;
            match_d  = '0;
            err_d    = '0;
            fidx_d   = '0;
            fres_d   = '0;
            fref_d   = '0;
        end else if (state_q == RUN) begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + LW'(1);
                2'b01:   count_d = count_q - LW'(1);
                default: count_d = count_q;
            endcase
            if (ovf_evt) begin
                ovf_d = 1'b1;
            end
            if (under) begin
                unf_d = 1'b1;
            end
            if (do_cmp) begin
                txn_d = sat_inc(txn_q);
                if (mismatch) begin
                    err_d    = sat_inc(err_q);
                    error_d  = 1'b1;
                    sticky_d = 1'b1;
                    if (!sticky_q) begin
                        fidx_d = txn_q;
                        fres_d = res_data;
                        fref_d = cmp_ref;
                    end
                    if (STOP_ON_ERR != 0) begin
                        state_d = HALT;
                    end
                end else begin
                    match_d = sat_inc(match_q);
                end
            end
        end
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
            sticky_q <= 1'b0;
            halted_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            txn_q    <= '0;
            match_q  <= '0;
            err_q    <= '0;
            fidx_q   <= '0;
            fres_q   <= '0;
            fref_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
            sticky_q <= sticky_d;
            halted_q <= halted_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            txn_q    <= txn_d;
            match_q  <= match_d;
            err_q    <= err_d;
            fidx_q   <= fidx_d;
            fres_q   <= fres_d;
            fref_q   <= fref_d;
        end
    end

    // Storage needs no reset: the pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ref_data;
        end
    end

    assign error         = error_q;
    assign err_sticky    = sticky_q;
    assign halted        = halted_q;
    assign overflow      = ovf_q;
    assign underflow     = unf_q;
    assign level         = count_q;
    assign txn_cnt       = txn_q;
    assign match_cnt     = match_q;
    assign err_cnt       = err_q;
    assign first_err_idx = fidx_q;
    assign first_err_res = fres_q;
    assign first_err_ref = fref_q;

endmodule

// File: tb/tb_adder_scoreboard.sv
// Bench for adder_scoreboard: a queue model tracks expected words and
// counters; each scenario task checks the DUT against it and fixed values.
module tb_adder_scoreboard;

    logic        clk = 1'b0;
    logic        rst, clear, ref_valid, res_valid;
    logic [16:0] ref_data, res_data;

    logic        error, err_sticky, halted, overflow, underflow;
    logic [3:0]  level;
    logic [15:0] txn_cnt, match_cnt, err_cnt, first_err_idx;
    logic [16:0] first_err_res, first_err_ref;

    logic        h_error, h_err_sticky, h_halted, h_overflow, h_underflow;
    logic [3:0]  h_level;
    logic [15:0] h_txn_cnt, h_match_cnt, h_err_cnt, h_first_err_idx;
    logic [16:0] h_first_err_res, h_first_err_ref;

    int n_chk = 0;
    int n_pass = 0;

    logic [16:0] m_exp[$];
    int          m_txn, m_match, m_err;
    logic        m_error, m_sticky, m_ovf, m_unf;
    int          m_fidx;
    logic [16:0] m_fres, m_fref;

    always #5 clk = ~clk;

    adder_scoreboard #(.WIDTH(17), .DEPTH(8), .CNT_W(16), .STOP_ON_ERR(0)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .ref_valid(ref_valid), .ref_data(ref_data),
        .res_valid(res_valid), .res_data(res_data),
        .error(error), .err_sticky(err_sticky), .halted(halted),
        .overflow(overflow), .underflow(underflow), .level(level),
        .txn_cnt(txn_cnt), .match_cnt(match_cnt), .err_cnt(err_cnt),
        .first_err_idx(first_err_idx), .first_err_res(first_err_res),
        .first_err_ref(first_err_ref)
    );

    adder_scoreboard #(.WIDTH(17), .DEPTH(8), .CNT_W(16), .STOP_ON_ERR(1)) dut_h (
        .clk(clk), .rst(rst), .clear(clear),
        .ref_valid(ref_valid), .ref_data(ref_data),
        .res_valid(res_valid), .res_data(res_data),
        .error(h_error), .err_sticky(h_err_sticky), .halted(h_halted),
        .overflow(h_overflow), .underflow(h_underflow), .level(h_level),
        .txn_cnt(h_txn_cnt), .match_cnt(h_match_cnt), .err_cnt(h_err_cnt),
        .first_err_idx(h_first_err_idx), .first_err_res(h_first_err_res),
        .first_err_ref(h_first_err_ref)
    );

    task automatic model_reset();
        m_exp.delete();
        m_txn = 0; m_match = 0; m_err = 0; m_fidx = 0;
        m_error = 0; m_sticky = 0; m_ovf = 0; m_unf = 0;
        m_fres = '0; m_fref = '0;
    endtask

    task automatic model_step(input logic rv, input logic [16:0] rd,
                              input logic sv, input logic [16:0] sd);
        logic        was_empty, have, pass;
        logic [16:0] r;
        was_empty = (m_exp.size() == 0);
        m_error = 0;
        r = '0;
        if (sv) begin
            have = 1;
            if (!was_empty) r = m_exp.pop_front();
            else if (rv) r = rd;
            else begin have = 0; m_unf = 1; end
            pass = have && (sd === r);
            if (pass) m_match++;
            else begin
                if (!m_sticky) begin m_fidx = m_txn; m_fres = sd; m_fref = r; end
                m_sticky = 1; m_err++; m_error = 1;
            end
            m_txn++;
            if (rv && !was_empty) m_exp.push_back(rd);
        end else if (rv) begin
            if (m_exp.size() < 8) m_exp.push_back(rd);
            else m_ovf = 1;
        end
    endtask

    task automatic cyc(input logic rv, input logic [16:0] rd,
                       input logic sv, input logic [16:0] sd);
        ref_valid = rv; ref_data = rd; res_valid = sv; res_data = sd;
        @(posedge clk);
        model_step(rv, rd, sv, sd);
        #1;
        ref_valid = 0; res_valid = 0; ref_data = '0; res_data = '0;
    endtask

    task automatic do_clear();
        clear = 1;
        @(posedge clk);
        model_reset();
        #1;
        clear = 0;
    endtask

    task automatic test_reset();
        n_chk++; if ({error, err_sticky, halted, overflow, underflow} !== 5'b0) $display("FAIL rst_flags got=%b want=00000", {error, err_sticky, halted, overflow, underflow}); else n_pass++;
        n_chk++; if (level !== 4'd0) $display("FAIL rst_level got=%0d want=0", level); else n_pass++;
        n_chk++; if ({txn_cnt, match_cnt, err_cnt} !== 48'd0) $display("FAIL rst_counters got=%h want=0", {txn_cnt, match_cnt, err_cnt}); else n_pass++;
        n_chk++; if ({first_err_idx, first_err_res, first_err_ref} !== 50'd0) $display("FAIL rst_captures got=%h want=0", {first_err_idx, first_err_res, first_err_ref}); else n_pass++;
    endtask

    task automatic test_in_order();
        logic [16:0] v[3];
        int          err_seen;
        v[0] = 17'h00001; v[1] = 17'h1FFFF; v[2] = 17'h0A5A5;
        err_seen = 0;
        do_clear();
        for (int c = 0; c < 5; c++) begin
            cyc(c < 3, (c < 3) ? v[c] : 17'h0, c >= 2, (c >= 2) ? v[c-2] : 17'h0);
            if (error) err_seen++;
            n_chk++; if (level !== 4'(m_exp.size())) $display("FAIL inorder_level c=%0d got=%0d want=%0d", c, level, m_exp.size()); else n_pass++;
        end
        n_chk++; if (match_cnt !== 16'd3) $display("FAIL inorder_match got=%0d want=3", match_cnt); else n_pass++;
        n_chk++; if (err_cnt !== 16'd0 || err_seen != 0) $display("FAIL inorder_err got=%0d pulses=%0d want=0", err_cnt, err_seen); else n_pass++;
        n_chk++; if (level !== 4'd0) $display("FAIL inorder_final_level got=%0d want=0", level); else n_pass++;
    endtask

    task automatic test_mismatch();
        do_clear();
        cyc(1, 17'h00010, 0, '0);
        cyc(1, 17'h00020, 0, '0);
        cyc(0, '0, 1, 17'h00010);
        n_chk++; if (error !== 1'b0) $display("FAIL mm_first_ok got=%b want=0", error); else n_pass++;
        cyc(0, '0, 1, 17'h00021);
        n_chk++; if (error !== 1'b1) $display("FAIL mm_pulse got=%b want=1", error); else n_pass++;
        n_chk++; if (first_err_idx !== 16'd1) $display("FAIL mm_idx got=%0d want=1", first_err_idx); else n_pass++;
        n_chk++; if (first_err_res !== 17'h00021 || first_err_ref !== 17'h00020) $display("FAIL mm_operands got=%h/%h want=00021/00020", first_err_res, first_err_ref); else n_pass++;
        cyc(0, '0, 0, '0);
        n_chk++; if (error !== 1'b0 || err_sticky !== 1'b1) $display("FAIL mm_sticky err=%b sticky=%b want=0/1", error, err_sticky); else n_pass++;
        n_chk++; if (err_cnt !== 16'd1 || match_cnt !== 16'd1) $display("FAIL mm_counts err=%0d match=%0d want=1/1", err_cnt, match_cnt); else n_pass++;
    endtask

    task automatic test_x_detect();
        logic [16:0] xv;
        xv = 17'h0000x;
        do_clear();
        cyc(1, 17'h00003, 0, '0);
        cyc(0, '0, 1, xv);
        n_chk++; if (error !== m_error) $display("FAIL x_pulse got=%b want=%b", error, m_error); else n_pass++;
        n_chk++; if (err_cnt !== 16'(m_err)) $display("FAIL x_errcnt got=%0d want=%0d", err_cnt, m_err); else n_pass++;
        cyc(1, xv, 0, '0);
        cyc(0, '0, 1, xv);
        n_chk++; if (error !== 1'b0 || match_cnt !== 16'(m_match)) $display("FAIL x_same err=%b match=%0d want=0/%0d", error, match_cnt, m_match); else n_pass++;
    endtask

    task automatic test_full_empty();
        do_clear();
        for (int i = 0; i < 9; i++) begin
            cyc(1, 17'(32'h100 + i), 0, '0);
            if (i == 7) begin
                n_chk++; if (overflow !== 1'b0 || level !== 4'd8) $display("FAIL full_at8 ovf=%b level=%0d want=0/8", overflow, level); else n_pass++;
            end
        end
        n_chk++; if (overflow !== 1'b1 || level !== 4'd8) $display("FAIL full_ovf ovf=%b level=%0d want=1/8", overflow, level); else n_pass++;
        cyc(1, 17'h00200, 1, 17'h00100);
        n_chk++; if (level !== 4'd8 || match_cnt !== 16'(m_match) || error !== 1'b0) $display("FAIL full_pushpop level=%0d match=%0d err=%b want=8/%0d/0", level, match_cnt, error, m_match); else n_pass++;
        for (int i = 0; i < 8; i++) cyc(0, '0, 1, m_exp[0]);
        n_chk++; if (level !== 4'd0 || err_cnt !== 16'd0 || match_cnt !== 16'(m_match)) $display("FAIL drain level=%0d err=%0d match=%0d want=0/0/%0d", level, err_cnt, match_cnt, m_match); else n_pass++;
        cyc(0, '0, 1, 17'h00055);
        n_chk++; if (underflow !== 1'b1 || err_cnt !== 16'd1 || error !== 1'b1) $display("FAIL underflow unf=%b err=%0d pulse=%b want=1/1/1", underflow, err_cnt, error); else n_pass++;
        cyc(1, 17'h00042, 1, 17'h00042);
        n_chk++; if (error !== 1'b0 || level !== 4'd0 || match_cnt !== 16'(m_match)) $display("FAIL bypass err=%b level=%0d match=%0d want=0/0/%0d", error, level, match_cnt, m_match); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_clear();
        cyc(1, 17'h00111, 0, '0);
        cyc(1, 17'h00222, 0, '0);
        cyc(0, '0, 1, 17'h00000);
        n_chk++; if (error !== 1'b1) $display("FAIL b2b_first got=%b want=1", error); else n_pass++;
        cyc(0, '0, 1, 17'h00001);
        n_chk++; if (error !== 1'b1 || err_cnt !== 16'd2) $display("FAIL b2b_second err=%b cnt=%0d want=1/2", error, err_cnt); else n_pass++;
        n_chk++; if (first_err_idx !== 16'd0 || first_err_ref !== 17'h00111) $display("FAIL b2b_capture idx=%0d ref=%h want=0/00111", first_err_idx, first_err_ref); else n_pass++;
    endtask

    task automatic test_halt();
        logic [16:0] r[5];
        do_clear();
        for (int i = 0; i < 5; i++) cyc(1, 17'(i + 1), 0, '0);
        r[0] = 17'd1; r[1] = 17'd2; r[2] = 17'd99; r[3] = 17'd4; r[4] = 17'd5;
        for (int i = 0; i < 5; i++) begin
            cyc(0, '0, 1, r[i]);
            if (i == 2) begin
                n_chk++; if (h_halted !== 1'b1 || h_error !== 1'b1) $display("FAIL halt_rise halted=%b err=%b want=1/1", h_halted, h_error); else n_pass++;
            end
        end
        cyc(1, 17'h00007, 0, '0);
        n_chk++; if (h_txn_cnt !== 16'd3 || h_err_cnt !== 16'd1 || h_match_cnt !== 16'd2) $display("FAIL halt_frozen txn=%0d err=%0d match=%0d want=3/1/2", h_txn_cnt, h_err_cnt, h_match_cnt); else n_pass++;
        n_chk++; if (h_level !== 4'd2 || h_halted !== 1'b1 || h_error !== 1'b0) $display("FAIL halt_state level=%0d halted=%b err=%b want=2/1/0", h_level, h_halted, h_error); else n_pass++;
        n_chk++; if (txn_cnt !== 16'd5 || halted !== 1'b0) $display("FAIL nohalt_runs txn=%0d halted=%b want=5/0", txn_cnt, halted); else n_pass++;
        do_clear();
        n_chk++; if (h_halted !== 1'b0 || h_txn_cnt !== 16'd0 || h_err_cnt !== 16'd0 || h_level !== 4'd0) $display("FAIL halt_clear halted=%b txn=%0d err=%0d level=%0d want=0", h_halted, h_txn_cnt, h_err_cnt, h_level); else n_pass++;
        cyc(1, 17'h00033, 1, 17'h00033);
        n_chk++; if (h_match_cnt !== 16'd1 || h_halted !== 1'b0) $display("FAIL halt_resume match=%0d halted=%b want=1/0", h_match_cnt, h_halted); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_clear();
        for (int i = 0; i < 6; i++) cyc(1, 17'(i), 0, '0);
        cyc(0, '0, 1, 17'h10000);
        cyc(0, '0, 1, 17'h10001);
        n_chk++; if (level !== 4'd4 || err_cnt !== 16'd2) $display("FAIL pre_rst level=%0d err=%0d want=4/2", level, err_cnt); else n_pass++;
        #2 rst = 1;
        #1;
        n_chk++; if (level !== 4'd0 || {txn_cnt, match_cnt, err_cnt} !== 48'd0) $display("FAIL async_rst_cnt level=%0d cnt=%h want=0", level, {txn_cnt, match_cnt, err_cnt}); else n_pass++;
        n_chk++; if ({error, err_sticky, halted, overflow, underflow} !== 5'b0 || {first_err_idx, first_err_res, first_err_ref} !== 50'd0) $display("FAIL async_rst_flags flags=%b cap=%h want=0", {error, err_sticky, halted, overflow, underflow}, {first_err_idx, first_err_res, first_err_ref}); else n_pass++;
        @(posedge clk);
        #2 rst = 0;
        model_reset();
        cyc(1, 17'h00077, 1, 17'h00077);
        cyc(1, 17'h00078, 0, '0);
        cyc(0, '0, 1, 17'h00078);
        n_chk++; if (match_cnt !== 16'd2 || err_cnt !== 16'd0 || level !== 4'd0) $display("FAIL post_rst match=%0d err=%0d level=%0d want=2/0/0", match_cnt, err_cnt, level); else n_pass++;
    endtask

    initial begin
        rst = 1; clear = 0; ref_valid = 0; res_valid = 0; ref_data = '0; res_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        test_reset();
        test_in_order();
        test_mismatch();
        test_x_detect();
        test_full_empty();
        test_back_to_back();
        test_halt();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/adder_scoreboard.md
# adder_scoreboard

Parametrised result checker for the adder test bench, placed between the reference model and the DUT output. Expected values are queued in an in-order FIFO so DUT pipeline latency is absorbed. Each DUT result is compared with the oldest queued expected value. The block keeps pass/fail counters, captures the first failure, and can halt checking on the first error.

## Interface
- WIDTH, 17: bit width of result and reference words.
- DEPTH, 8: reference FIFO entries; power of two, at least 2.
- CNT_W, 16: width of the match, error and transaction counters.
- STOP_ON_ERR, 0: when 1, the block enters HALT after the first error.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- clear  in  1  synchronous flush of FIFO, counters, captures and flags; returns to RUN.
- ref_valid  in  1  pushes ref_data into the FIFO this cycle.
- ref_data  in  WIDTH  expected value.
- res_valid  in  1  DUT result valid this cycle; pops and compares.
- res_data  in  WIDTH  DUT result.
- error  out  1  one-cycle pulse for each failed comparison.
- err_sticky  out  1  set by the first error; held until clear or rst.
- halted  out  1  high while the FSM is in HALT.
- overflow  out  1  sticky; a push was dropped because the FIFO was full.
- underflow  out  1  sticky; a result arrived with no expected value available.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- txn_cnt, match_cnt, err_cnt  out  CNT_W each  compared results, passes and failures.
- first_err_idx  out  CNT_W  txn_cnt value of the first failure.
- first_err_res, first_err_ref  out  WIDTH each  operands of the first failure.

## Operation
- FSM has two states, RUN and HALT.
  - Reset and clear both go to RUN.
  - RUN goes to HALT on an error only when STOP_ON_ERR=1.
  - HALT is left only by clear or rst.
  - In HALT, ref_valid and res_valid are ignored. FIFO, counters and captures freeze.
- Push: ref_valid with the FIFO not full writes ref_data at the tail.
- Full with ref_valid:
  - without res_valid: the data is dropped and overflow is set;
  - with res_valid: the push and pop both happen and level is unchanged.
- Compare: on res_valid, res_data is checked against the FIFO head using 4-state case-equality. Any bit that is X/Z on one side but not identical on the other is a mismatch.
- Empty FIFO with res_valid and ref_valid together: bypass. res_data is compared with ref_data directly, nothing is stored, and level stays 0.
- Empty FIFO with res_valid but no ref_valid: underflow is set and the result counts as an error. first_err_ref captures all-X.
- On each compare in RUN:
  - txn_cnt increments;
  - a pass increments match_cnt;
  - a fail increments err_cnt, pulses error and sets err_sticky;
  - on the first fail only, first_err_* capture txn_cnt (the pre-increment value) and both operands.
- All counters saturate at 2^CNT_W-1. They never wrap.
- clear has priority over push and pop in the same cycle.

## Timing
- Reset values:
  - error, err_sticky, halted, overflow, underflow: 0;
  - level and all counters: 0;
  - first_err_idx: 0;
  - first_err_res, first_err_ref: 0;
  - FSM state: RUN.
- All outputs are registered and update on the clk edge that samples the inputs. Compare-to-flag latency is 1 cycle.
- error is high for exactly one cycle per failing result. Back-to-back failures give back-to-back pulses.
- halted rises in the same cycle error rises. Transactions in the following cycles are ignored.
- A push and a pop in the same cycle on a non-empty FIFO:
  - the pop compares against the old head;
  - the new entry goes to the tail.
- rst asserted mid-operation clears everything immediately, including in-flight FIFO contents, regardless of clk.

## Test plan
- In-order pass: push 0x00001, 0x1FFFF, 0x0A5A5, then present the same three results 2 cycles later -> match_cnt=3, err_cnt=0, error never high, level returns to 0.
- Single mismatch: push 0x00010 and 0x00020, results 0x00010 and 0x00021 -> one error pulse on the second compare, first_err_idx=1, first_err_res=0x00021, first_err_ref=0x00020, err_sticky=1.
- X detection: push 0x00003, result 0x0000X -> error pulse and err_cnt=1. A second push 0x0000X with result 0x0000X -> pass.
- Full/empty boundaries:
  - with DEPTH=8, push 9 values with no results -> overflow=1, level=8;
  - result with FIFO empty and no push -> underflow=1, err_cnt+1;
  - simultaneous push/result on empty, both 0x00042 -> pass, level=0.
- STOP_ON_ERR=1: mismatch on transaction 2 of 5 -> halted=1, txn_cnt=3 and frozen. clear -> halted=0, counters 0, FIFO empty.
- Reset mid-stream: assert rst asynchronously with level=4 and err_cnt=2 -> all outputs read 0 before the next clk edge.
